// File: rtl/lcd_ctrl_gen2.sv
// 2x2-window image processor: loads an IMG_DIM x IMG_DIM image from ROM, applies window
// ops around a movable point, and dumps the image to RAM on WRITE.
module lcd_ctrl_gen2 #(
  parameter  int IMG_DIM = 8,
  parameter  int DW      = 8,
  localparam int AW      = 2*$clog2(IMG_DIM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          rom_rd,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q,
  output logic          ram_valid,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          busy,
  output logic          done
);
  localparam int N  = IMG_DIM*IMG_DIM;
  localparam int LW = $clog2(IMG_DIM);
  localparam logic [AW:0]   CNT_N    = (AW+1)'(N);
  localparam logic [AW:0]   CNT_LAST = (AW+1)'(N-1);
  localparam logic [LW-1:0] P_CTR    = LW'(IMG_DIM/2);
  localparam logic [LW-1:0] P_MAX    = LW'(IMG_DIM-1);
  localparam logic [LW-1:0] P_MIN    = LW'(1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE} state_t;

  state_t        state, state_nx;
  logic [AW:0]   cnt;
  logic [3:0]    cmd_q;
  logic [LW-1:0] px, py;
  logic [DW-1:0] store [N];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_LOAD;
    else        state <= state_nx;

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (cnt == CNT_N) state_nx = S_IDLE;
      S_IDLE:  if (cmd_valid) state_nx = (cmd == 4'h0) ? S_WRITE : S_EXEC;
      S_EXEC:  state_nx = S_IDLE;
      S_WRITE: if (cnt == CNT_LAST) state_nx = S_IDLE;
      default: state_nx = S_LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // rom_rd is gated by reset so the ROM is never read while reset is held.
  always_comb begin
    busy      = (state != S_IDLE);
    rom_rd    = reset && (state == S_LOAD) && (cnt < CNT_N);
    rom_a     = (state == S_LOAD) ? cnt[AW-1:0] : '0;
    ram_valid = (state == S_WRITE);
    ram_a     = ram_valid ? cnt[AW-1:0] : '0;
    ram_d     = ram_valid ? store[ram_a] : '0;
  end

  // Shared counter: LOAD address/capture index, WRITE address.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                                   cnt <= '0;
    else if (state_nx != state || state == S_IDLE) cnt <= '0;
    else                                          cnt <= cnt + 1'b1;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cmd_q <= '0;
      done  <= 1'b0;
    end else begin
      if (state == S_IDLE && cmd_valid) cmd_q <= cmd;
      done <= (state == S_WRITE) && (cnt == CNT_LAST);
    end

  // ---------------- window point ----------------
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      px <= P_CTR;
      py <= P_CTR;
    end else if (state == S_EXEC) begin
      case (cmd_q)
        4'h1: if (py != P_MIN) py <= py - 1'b1;
        4'h2: if (py != P_MAX) py <= py + 1'b1;
        4'h3: if (px != P_MIN) px <= px - 1'b1;
        4'h4: if (px != P_MAX) px <= px + 1'b1;
        4'hC: begin px <= P_CTR; py <= P_CTR; end
        default: ;
      endcase
    end

  // ---------------- window datapath ----------------
  logic [LW-1:0] pxm1, pym1;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br, ld_a;
  logic [DW-1:0] v_tl, v_tr, v_bl, v_br, n_tl, n_tr, n_bl, n_br;
  logic [DW-1:0] mx_t, mx_b, mx, mn_t, mn_b, mn;
  logic [DW+1:0] sum;
  logic          win_we;

  assign pxm1 = px - 1'b1;
  assign pym1 = py - 1'b1;
  assign a_tl = {pym1, pxm1};
  assign a_tr = {pym1, px};
  assign a_bl = {py, pxm1};
  assign a_br = {py, px};
  assign ld_a = cnt[AW-1:0] - 1'b1;

  assign v_tl = store[a_tl];
  assign v_tr = store[a_tr];
  assign v_bl = store[a_bl];
  assign v_br = store[a_br];

  assign mx_t = (v_tl > v_tr) ? v_tl : v_tr;
  assign mx_b = (v_bl > v_br) ? v_bl : v_br;
  assign mx   = (mx_t > mx_b) ? mx_t : mx_b;
  assign mn_t = (v_tl < v_tr) ? v_tl : v_tr;
  assign mn_b = (v_bl < v_br) ? v_bl : v_br;
  assign mn   = (mn_t < mn_b) ? mn_t : mn_b;
  assign sum  = {2'b00, v_tl} + {2'b00, v_tr} + {2'b00, v_bl} + {2'b00, v_br};

  always_comb begin
    n_tl   = v_tl;
    n_tr   = v_tr;
    n_bl   = v_bl;
    n_br   = v_br;
    win_we = (state == S_EXEC);
    case (cmd_q)
      4'h5: begin n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx; end
      4'h6: begin n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn; end
      4'h7: begin
        n_tl = sum[DW+1:2]; n_tr = sum[DW+1:2];
        n_bl = sum[DW+1:2]; n_br = sum[DW+1:2];
      end
      4'h8: begin n_tl = v_tr; n_tr = v_br; n_br = v_bl; n_bl = v_tl; end
      4'h9: begin n_tl = v_bl; n_bl = v_br; n_br = v_tr; n_tr = v_tl; end
      4'hA: begin n_tl = v_bl; n_bl = v_tl; n_tr = v_br; n_br = v_tr; end
      4'hB: begin n_tl = v_tr; n_tr = v_tl; n_bl = v_br; n_br = v_bl; end
      4'hD: begin n_tl = '0; n_tr = '0; n_bl = '0; n_br = '0; end
      default: win_we = 1'b0;
    endcase
  end

  // Image store has no reset; LOAD defines every entry before first use.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && cnt != '0) store[ld_a] <= rom_q;
    if (win_we) begin
      store[a_tl] <= n_tl;
      store[a_tr] <= n_tr;
      store[a_bl] <= n_bl;
      store[a_br] <= n_br;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_gen2.sv
// Directed bench for lcd_ctrl_gen2: command model + RAM-dump scoreboard, plus a 16x16/10-bit instance.
module tb_lcd_ctrl_gen2;
  localparam int N   = 64;
  localparam int N16 = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic       rom_rd, ram_valid, busy, done;
  logic [5:0] rom_a, ram_a;
  logic [7:0] rom_q, ram_d;

  logic       reset16 = 1'b0;
  logic [3:0] cmd16 = '0;
  logic       cmd_valid16 = 1'b0;
  logic       rom_rd16, ram_valid16, busy16, done16;
  logic [7:0] rom_a16, ram_a16;
  logic [9:0] rom16_q, ram_d16;

  always #5 clk = ~clk;

  lcd_ctrl_gen2 #(.IMG_DIM(8), .DW(8)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .rom_rd(rom_rd), .rom_a(rom_a), .rom_q(rom_q),
    .ram_valid(ram_valid), .ram_a(ram_a), .ram_d(ram_d),
    .busy(busy), .done(done));

  lcd_ctrl_gen2 #(.IMG_DIM(16), .DW(10)) dut16 (
    .clk(clk), .reset(reset16), .cmd(cmd16), .cmd_valid(cmd_valid16),
    .rom_rd(rom_rd16), .rom_a(rom_a16), .rom_q(rom16_q),
    .ram_valid(ram_valid16), .ram_a(ram_a16), .ram_d(ram_d16),
    .busy(busy16), .done(done16));

  logic [7:0] rom [N];
  logic [9:0] rom16 [N16];
  always @(posedge clk) begin
    rom_q   <= rom[rom_a];
    rom16_q <= rom16[rom_a16];
  end

  typedef struct { int a; int d; } exp_t;
  exp_t sbq[$];
  int   img [N];
  int   px, py;
  logic [7:0] ram_mem [N];
  int   n_tests = 0, n_fail = 0;
  int   ram_cyc = 0, done_cnt = 0, w16 = 0, done16_cnt = 0;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // ---------------- monitors ----------------
  initial forever begin
    @(negedge clk);
    if (ram_valid === 1'b1) begin
      ram_mem[ram_a] = ram_d;
      ram_cyc++;
      if (sbq.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL sb_unexpected: observed write at %0d expected none", ram_a);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_ram_a", 32'(ram_a), e.a);
        chk("sb_ram_d", 32'(ram_d), e.d);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (ram_valid16 === 1'b1) begin
      chk("t5_ram_a", 32'(ram_a16), w16);
      chk("t5_ram_d", 32'(ram_d16), 32'h3FF);
      w16++;
    end
    if (done16 === 1'b1) done16_cnt++;
  end

  // ---------------- reference model ----------------
  task automatic model(input int c);
    int tl, tr, bl, br, v0, v1, v2, v3, m;
    tl = (py-1)*8 + (px-1); tr = tl + 1; bl = tl + 8; br = bl + 1;
    v0 = img[tl]; v1 = img[tr]; v2 = img[bl]; v3 = img[br];
    case (c)
      1: if (py > 1) py--;
      2: if (py < 7) py++;
      3: if (px > 1) px--;
      4: if (px < 7) px++;
      5: begin m = v0; if (v1 > m) m = v1; if (v2 > m) m = v2; if (v3 > m) m = v3;
           img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m; end
      6: begin m = v0; if (v1 < m) m = v1; if (v2 < m) m = v2; if (v3 < m) m = v3;
           img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m; end
      7: begin m = (v0 + v1 + v2 + v3) / 4;
           img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m; end
      8:  begin img[tl] = v1; img[tr] = v3; img[br] = v2; img[bl] = v0; end
      9:  begin img[tl] = v2; img[bl] = v3; img[br] = v1; img[tr] = v0; end
      10: begin img[tl] = v2; img[tr] = v3; img[bl] = v0; img[br] = v1; end
      11: begin img[tl] = v1; img[tr] = v0; img[bl] = v3; img[br] = v2; end
      12: begin px = 4; py = 4; end
      13: begin img[tl] = 0; img[tr] = 0; img[bl] = 0; img[br] = 0; end
      default: ;
    endcase
  endtask

  task automatic push_dump();
    for (int a = 0; a < N; a++) sbq.push_back('{a, img[a]});
  endtask

  task automatic rom_ramp();
    for (int a = 0; a < N; a++) rom[a] = 8'(a);
  endtask

  task automatic set_win(input int tl, input int tr, input int bl, input int br);
    rom_ramp();
    rom[27] = 8'(tl); rom[28] = 8'(tr); rom[35] = 8'(bl); rom[36] = 8'(br);
  endtask

  // Reset with checks of reset-state outputs and LOAD length; leaves us on a negedge in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 1);   chk("rst_done", 32'(done), 0);
    chk("rst_rom_rd", 32'(rom_rd), 0); chk("rst_ram_valid", 32'(ram_valid), 0);
    chk("rst_rom_a", 32'(rom_a), 0); chk("rst_ram_a", 32'(ram_a), 0);
    chk("rst_ram_d", 32'(ram_d), 0);
    @(negedge clk);
    sbq.delete();
    for (int a = 0; a < N; a++) img[a] = int'(rom[a]);
    px = 4; py = 4;
    reset = 1'b1;
    #1;
    chk("load_rom_rd0", 32'(rom_rd), 1);
    chk("load_rom_a0", 32'(rom_a), 0);
    for (int k = 1; k <= N+1; k++) begin
      @(negedge clk);
      if (k == 1) chk("load_rom_a1", 32'(rom_a), 1);
      if (k == N) begin chk("load_busy_N", 32'(busy), 1); chk("load_rom_rd_N", 32'(rom_rd), 0); end
    end
    chk("load_busy_done", 32'(busy), 0);
  endtask

  task automatic do_cmd(input logic [3:0] c, input bit poke);
    int k, cyc0;
    k = 0;
    while (busy !== 1'b0 && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) chk("idle_timeout", 32'(busy), 0);
    if (c == 4'h0) push_dump();
    cyc0 = ram_cyc;
    cmd = c; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_cmd", 32'(busy), 1);
    if (c != 4'h0) begin
      model(int'(c));
      @(negedge clk);
      chk("busy_one_cycle", 32'(busy), 0);
    end else begin
      if (poke) begin
        cmd = 4'h4; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
      end
      k = 0;
      while (done !== 1'b1 && k < N+10) begin @(negedge clk); k++; end
      chk("done_seen", 32'(done), 1);
      chk("busy_at_done", 32'(busy), 0);
      chk("write_len", 32'(ram_cyc - cyc0), N);
      chk("sb_drained", 32'(sbq.size()), 0);
    end
  endtask

  initial begin
    int dc0, k;
    for (int a = 0; a < N16; a++) rom16[a] = 10'h3FF;

    // T1: ramp image dumped verbatim; a command during WRITE is dropped
    rom_ramp();
    do_reset();
    dc0 = done_cnt;
    do_cmd(4'h0, 1'b1);
    chk("t1_ram63", 32'(ram_mem[63]), 63);
    chk("t1_ram0", 32'(ram_mem[0]), 0);
    chk("t1_one_done", 32'(done_cnt - dc0), 1);

    // T2: saturating shifts, clear at corner, recenter
    for (int i = 0; i < 5; i++) do_cmd(4'h4, 1'b0);
    for (int i = 0; i < 5; i++) do_cmd(4'h2, 1'b0);
    do_cmd(4'hD, 1'b0);
    do_cmd(4'hC, 1'b0);
    do_cmd(4'hD, 1'b0);
    do_cmd(4'h0, 1'b0);
    chk("t2_ram63", 32'(ram_mem[63]), 0);
    chk("t2_ram54", 32'(ram_mem[54]), 0);
    chk("t2_ram36", 32'(ram_mem[36]), 0);
    chk("t2_ram45", 32'(ram_mem[45]), 45);
    // low-side saturation
    for (int i = 0; i < 5; i++) do_cmd(4'h3, 1'b0);
    for (int i = 0; i < 5; i++) do_cmd(4'h1, 1'b0);
    do_cmd(4'hD, 1'b0);
    do_cmd(4'hE, 1'b0);
    do_cmd(4'h0, 1'b0);
    chk("t2_ram9", 32'(ram_mem[9]), 0);
    chk("t2_ram10", 32'(ram_mem[10]), 10);

    // T3: max / min / avg
    set_win(10, 20, 30, 40);
    do_reset();
    do_cmd(4'h5, 1'b0); do_cmd(4'h0, 1'b0);
    chk("t3_max_tl", 32'(ram_mem[27]), 40);
    do_reset();
    do_cmd(4'h6, 1'b0); do_cmd(4'h0, 1'b0);
    chk("t3_min_br", 32'(ram_mem[36]), 10);
    set_win(10, 11, 12, 13);
    do_reset();
    do_cmd(4'h7, 1'b0); do_cmd(4'h0, 1'b0);
    chk("t3_avg_bl", 32'(ram_mem[35]), 11);

    // T4: rotations and mirrors
    set_win(1, 2, 3, 4);
    do_reset();
    do_cmd(4'h8, 1'b0); do_cmd(4'h0, 1'b0);
    chk("t4_ccw", {ram_mem[27], ram_mem[28], ram_mem[35], ram_mem[36]}, 32'h02040103);
    do_cmd(4'h9, 1'b0); do_cmd(4'h0, 1'b0);
    chk("t4_cw", {ram_mem[27], ram_mem[28], ram_mem[35], ram_mem[36]}, 32'h01020304);
    do_cmd(4'hA, 1'b0); do_cmd(4'h0, 1'b0);
    chk("t4_mx", {ram_mem[27], ram_mem[28], ram_mem[35], ram_mem[36]}, 32'h03040102);
    do_cmd(4'hB, 1'b0); do_cmd(4'h0, 1'b0);
    chk("t4_my", {ram_mem[27], ram_mem[28], ram_mem[35], ram_mem[36]}, 32'h04030201);

    // T6: reset in the 20th WRITE cycle aborts the dump and restarts LOAD
    rom_ramp();
    do_reset();
    push_dump();
    cmd = 4'h0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("t6_ram_a19", 32'(ram_a), 19);
    reset = 1'b0;
    #1;
    chk("t6_abort_valid", 32'(ram_valid), 0);
    chk("t6_abort_busy", 32'(busy), 1);
    sbq.delete();
    dc0 = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_reload_rd", 32'(rom_rd), 1);
    chk("t6_reload_a", 32'(rom_a), 0);
    repeat (N+1) @(negedge clk);
    chk("t6_reload_idle", 32'(busy), 0);
    chk("t6_no_done", 32'(done_cnt - dc0), 0);
    px = 4; py = 4;
    do_cmd(4'h0, 1'b0);

    // T5: 16x16, 10-bit saturated window average and full dump
    @(negedge clk);
    reset16 = 1'b1;
    k = 0;
    while (busy16 !== 1'b0 && k < N16+20) begin @(negedge clk); k++; end
    chk("t5_load_len", k, N16+1);
    cmd16 = 4'h7; cmd_valid16 = 1'b1;
    @(negedge clk);
    cmd_valid16 = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy16), 0);
    cmd16 = 4'h0; cmd_valid16 = 1'b1;
    @(negedge clk);
    cmd_valid16 = 1'b0;
    k = 0;
    while (done16 !== 1'b1 && k < N16+20) begin @(negedge clk); k++; end
    chk("t5_done", 32'(done16), 1);
    chk("t5_writes", w16, N16);
    chk("t5_done_cnt", done16_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
